// File: rtl/cam_rgb565_capture_if.sv
// -----------------------------------------------------------------------------
// cam_rgb565_capture_if
// Pixel-buffer write bus between the camera capture stage and the 7040-entry
// pixel buffer read by the HDMI output stage.
//
// Handshake: WR_EN is a one-cycle valid strobe with no ready. The buffer
// accepts a word in every cycle, so each cycle with WR_EN=1 is one completed
// write of WR_DATA to WR_ADDR. WR_ADDR and WR_DATA are only meaningful while
// WR_EN=1.
//
// Signals:
//   WR_EN    1       write strobe, one clk wide
//   WR_ADDR  ADDR_W  buffer write address
//   WR_DATA  16      RGB565 word {R[4:0],G[5:0],B[4:0]}
// Modports:
//   master   driven by the capture stage
//   slave    seen by the pixel buffer
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface cam_rgb565_capture_if #(
  parameter int ADDR_W = 13
) ();
  logic              WR_EN;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [15:0]       WR_DATA;

  modport master (
    output WR_EN,
    output WR_ADDR,
    output WR_DATA
  );

  modport slave (
    input WR_EN,
    input WR_ADDR,
    input WR_DATA
  );
endinterface

// File: rtl/cam_rgb565_capture.sv
// -----------------------------------------------------------------------------
// cam_rgb565_capture
// Samples an 8-bit parallel camera bus (PCLK/VSYNC/HREF/DATA) in the system
// clock domain, pairs consecutive bytes of a line into RGB565 words and writes
// them into the pixel buffer at an auto-incrementing address that wraps at
// BUF_DEPTH-1. BUFFER_EN goes high with the first stored pixel and stays high
// until reset, releasing the HDMI timing generator.
//
// Parameters:
//   BUF_DEPTH    number of buffer entries (address wraps at BUF_DEPTH-1)
//   ADDR_W       write address width, 2**ADDR_W >= BUF_DEPTH
//   SYNC_STAGES  synchronizer depth on every camera input (>= 2)
//
// Ports:
//   clk          system/pixel clock
//   rst_n        synchronous active-low reset
//   CAM_PCLK     camera pixel clock, sampled as data
//   CAM_VSYNC    frame sync, high between frames
//   CAM_HREF     line valid
//   CAM_DATA     camera byte, valid on CAM_PCLK rising edge
//   wr_bus       buffer write bus (WR_EN / WR_ADDR / WR_DATA), master side
//   BUFFER_EN    sticky, set by the first write
//   FRAME_DONE   one-cycle pulse at the end of each captured frame
//   o_dbg_state  current capture state (IDLE=0, SYNC=1, ACTIVE=2)
//
// Timing: with E the clk cycle in which a second-byte PCLK rise is detected,
// WR_EN/WR_DATA/WR_ADDR are valid in E+1 and WR_ADDR advances in E+2.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module cam_rgb565_capture #(
  parameter int BUF_DEPTH   = 7040,
  parameter int ADDR_W      = 13,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         CAM_PCLK,
  input  logic                         CAM_VSYNC,
  input  logic                         CAM_HREF,
  input  logic [7:0]                   CAM_DATA,
  cam_rgb565_capture_if.master         wr_bus,
  output logic                         BUFFER_EN,
  output logic                         FRAME_DONE,
  output logic [1:0]                   o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BUF_DEPTH - 1);

  // ---------------------------------------------------------------------------
  // Input synchronizers. All four inputs share one depth so that a byte and
  // the PCLK edge that qualifies it leave the chains in the same cycle.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_pclk_sync;
  logic [SYNC_STAGES-1:0] r_vs_sync;
  logic [SYNC_STAGES-1:0] r_href_sync;
  logic [7:0]             r_data_sync [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pclk_sync <= '0;
      r_vs_sync   <= '0;
      r_href_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_data_sync[i] <= 8'h00;
      end
    end else begin
      r_pclk_sync    <= {r_pclk_sync[SYNC_STAGES-2:0], CAM_PCLK};
      r_vs_sync      <= {r_vs_sync[SYNC_STAGES-2:0],   CAM_VSYNC};
      r_href_sync    <= {r_href_sync[SYNC_STAGES-2:0], CAM_HREF};
      r_data_sync[0] <= CAM_DATA;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_data_sync[i] <= r_data_sync[i-1];
      end
    end
  end

  logic       w_pclk_s;
  logic       w_vs_s;
  logic       w_href_s;
  logic [7:0] w_data_s;

  assign w_pclk_s = r_pclk_sync[SYNC_STAGES-1];
  assign w_vs_s   = r_vs_sync[SYNC_STAGES-1];
  assign w_href_s = r_href_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Edge detection on the synchronized strobes
  // ---------------------------------------------------------------------------
  logic r_pclk_d;
  logic r_vs_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pclk_d <= 1'b0;
      r_vs_d   <= 1'b0;
    end else begin
      r_pclk_d <= w_pclk_s;
      r_vs_d   <= w_vs_s;
    end
  end

  logic w_pclk_rise;
  logic w_vs_rise;
  logic w_vs_fall;

  assign w_pclk_rise = w_pclk_s & ~r_pclk_d;
  assign w_vs_rise   = w_vs_s   & ~r_vs_d;
  assign w_vs_fall   = ~w_vs_s  &  r_vs_d;

  // ---------------------------------------------------------------------------
  // Capture state machine: state register
  // ---------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_nxt;
  logic   r_phase;       // 0: next byte is the high byte, 1: low byte
  logic   w_phase_nxt;
  logic   w_hi_load;     // latch current byte as the high byte
  logic   w_wr_fire;     // second byte of a pair seen: write next cycle
  logic   w_done_nxt;    // frame ended: pulse FRAME_DONE next cycle
  logic   w_enter_active;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_phase <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture state machine: next state and per-cycle decisions
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_phase_nxt    = 1'b0;
    w_hi_load      = 1'b0;
    w_wr_fire      = 1'b0;
    w_done_nxt     = 1'b0;
    w_enter_active = 1'b0;

    case (r_state)
      // Starting on a VSYNC rise guarantees the first frame is captured whole.
      ST_IDLE: begin
        if (w_vs_rise) begin
          w_state_nxt = ST_SYNC;
        end
      end

      ST_SYNC: begin
        if (w_vs_fall) begin
          w_state_nxt    = ST_ACTIVE;
          w_enter_active = 1'b1;
        end
      end

      ST_ACTIVE: begin
        // HREF low drops any dangling high byte so each line pairs from its
        // first byte.
        if (w_href_s) begin
          w_phase_nxt = r_phase;
          if (w_pclk_rise) begin
            if (r_phase) begin
              w_wr_fire   = 1'b1;
              w_phase_nxt = 1'b0;
            end else begin
              w_hi_load   = 1'b1;
              w_phase_nxt = 1'b1;
            end
          end
        end
        // A VSYNC rise ends the frame; a write detected in the same cycle is
        // still issued, only the state change takes priority.
        if (w_vs_rise) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_SYNC;
          w_phase_nxt = 1'b0;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  logic [7:0]        r_hi;
  logic              r_wr_en;
  logic [15:0]       r_wr_data;
  logic [ADDR_W-1:0] r_addr;
  logic              r_buf_en;
  logic              r_frame_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hi         <= 8'h00;
      r_wr_en      <= 1'b0;
      r_wr_data    <= 16'h0000;
      r_addr       <= '0;
      r_buf_en     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_hi_load) begin
        r_hi <= w_data_s;
      end

      r_wr_en <= w_wr_fire;
      if (w_wr_fire) begin
        r_wr_data <= {r_hi, w_data_s};
      end

      // The address stays on the written location during the strobe and
      // moves one cycle later; entering a new frame restarts it at 0.
      if (w_enter_active) begin
        r_addr <= '0;
      end else if (r_wr_en) begin
        if (r_addr == LAST_ADDR) begin
          r_addr <= '0;
        end else begin
          r_addr <= r_addr + ADDR_W'(1);
        end
      end

      r_buf_en     <= r_buf_en | w_wr_fire;
      r_frame_done <= w_done_nxt;
    end
  end

  assign wr_bus.WR_EN   = r_wr_en;
  assign wr_bus.WR_ADDR = r_addr;
  assign wr_bus.WR_DATA = r_wr_data;
  assign BUFFER_EN      = r_buf_en;
  assign FRAME_DONE     = r_frame_done;
  assign o_dbg_state    = r_state;

endmodule
